// File: rtl/rule_readback_for_dep_pkg.sv
// rule_readback_for_dep_pkg: deparser rule-table sizes, readback address classes and FSM states
package rule_readback_for_dep_pkg;
  localparam int RULE_NUM          = 32;
  localparam int TYPE_NUM          = 4;
  localparam int TYPE_WIDTH        = 16;
  localparam int TYPE_OFFSET_WIDTH = 8;
  localparam int KEY_FILED_NUM     = 8;
  localparam int KEY_OFFSET_WIDTH  = 8;
  localparam int HEAD_SHIFT_WIDTH  = 8;
  localparam int META_SHIFT_WIDTH  = 8;
  typedef enum logic [2:0] {
    CLS_TBL      = 3'd0,
    CLS_TYPE     = 3'd1,
    CLS_TYPE_OFF = 3'd2,
    CLS_KEY      = 3'd3,
    CLS_HEAD     = 3'd4,
    CLS_META     = 3'd5
  } rule_cls_e;
  typedef enum logic [2:0] {IDLE, LOCAL, TBL_REQ, TBL_WAIT, RESP} rd_state_e;
endpackage

// File: rtl/rule_rd_pack.sv
// rule_rd_pack: packs one configuration entry into the 32-bit readback word and flags illegal class/index
module rule_rd_pack
  import rule_readback_for_dep_pkg::*;
(
  input  logic [2:0]                                      cls,
  input  logic [5:0]                                      idx,
  input  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             type_data,
  input  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             type_mask,
  input  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]      type_offset,
  input  logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0]    key_offset,
  input  logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0]  key_replace,
  input  logic [HEAD_SHIFT_WIDTH-1:0]                     head_shift,
  input  logic [META_SHIFT_WIDTH-1:0]                     meta_shift,
  output logic [31:0]                                     data,
  output logic                                            illegal
);
  logic [$clog2(TYPE_NUM)-1:0]      ti;
  logic [$clog2(KEY_FILED_NUM)-1:0] ki;
  logic [31:0]                      raw;
  assign ti = idx[$clog2(TYPE_NUM)-1:0];
  assign ki = idx[$clog2(KEY_FILED_NUM)-1:0];
  always_comb begin
    raw = '0;
    illegal = 1'b0;
    case (cls)
      CLS_TBL: illegal = int'(idx) >= RULE_NUM;
      CLS_TYPE: begin
        raw[16+:TYPE_WIDTH] = type_data[ti];
        raw[0+:TYPE_WIDTH] = type_mask[ti];
        illegal = int'(idx[3:0]) >= TYPE_NUM;
      end
      CLS_TYPE_OFF: begin
        raw[0+:TYPE_OFFSET_WIDTH] = type_offset[ti];
        illegal = int'(idx[3:0]) >= TYPE_NUM;
      end
      CLS_KEY: begin
        raw[16] = key_offset[ki][KEY_OFFSET_WIDTH];
        raw[8+:KEY_OFFSET_WIDTH] = key_replace[ki];
        raw[0+:KEY_OFFSET_WIDTH] = key_offset[ki][KEY_OFFSET_WIDTH-1:0];
        illegal = int'(idx) >= KEY_FILED_NUM;
      end
      CLS_HEAD: raw[0+:HEAD_SHIFT_WIDTH] = head_shift;
      CLS_META: raw[0+:META_SHIFT_WIDTH] = meta_shift;
      default: illegal = 1'b1;
    endcase
  end
  assign data = illegal ? '0 : raw;
endmodule

// File: rtl/rule_readback_for_dep.sv
// rule_readback_for_dep: readback of deparser configuration; local classes answer from the config
// inputs, class 0 goes to the rule table with a timeout.
module rule_readback_for_dep
  import rule_readback_for_dep_pkg::*;
#(
  parameter int RD_TIMEOUT = 64,
  parameter int TO_WIDTH   = 8
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_rule_rden,
  input  logic [31:0]                                     i_rule_addr,
  output logic                                            o_rule_rdata_valid,
  output logic [31:0]                                     o_rule_rdata,
  output logic                                            o_rule_rd_err,
  output logic                                            o_rule_busy,
  output logic                                            o_rule_drop,
  input  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             i_typeRule_typeData,
  input  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]             i_typeRule_typeMask,
  input  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]      i_typeRule_typeOffset,
  input  logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0]    i_typeRule_keyOffset,
  input  logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0]  i_typeRule_keyReplaceOffset,
  input  logic [HEAD_SHIFT_WIDTH-1:0]                     i_typeRule_headShift,
  input  logic [META_SHIFT_WIDTH-1:0]                     i_typeRule_metaShift,
  output logic                                            o_ruleTbl_rden,
  output logic [5:0]                                      o_ruleTbl_addr,
  input  logic                                            i_ruleTbl_rdata_valid,
  input  logic [31:0]                                     i_ruleTbl_rdata
);
  rd_state_e           state, nxt;
  logic [2:0]          cls_q;
  logic [5:0]          idx_q;
  logic [TO_WIDTH-1:0] cnt;
  logic [31:0]         rdata_q, pk_data;
  logic                err_q, drop_q, pk_ill, go_tbl, timeout, unused;
  assign unused = ^{i_rule_addr[31:11], i_rule_addr[7:6]};
  // out-of-range class 0 indexes are answered locally as errors, never touching the table
  assign go_tbl = i_rule_addr[10:8] == CLS_TBL && int'(i_rule_addr[5:0]) < RULE_NUM;
  assign timeout = cnt == TO_WIDTH'(RD_TIMEOUT);
  rule_rd_pack u_pack (
    .cls(cls_q), .idx(idx_q),
    .type_data(i_typeRule_typeData), .type_mask(i_typeRule_typeMask),
    .type_offset(i_typeRule_typeOffset), .key_offset(i_typeRule_keyOffset),
    .key_replace(i_typeRule_keyReplaceOffset), .head_shift(i_typeRule_headShift),
    .meta_shift(i_typeRule_metaShift), .data(pk_data), .illegal(pk_ill)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = i_rule_rden ? (go_tbl ? TBL_REQ : LOCAL) : IDLE;
      LOCAL:    nxt = RESP;
      TBL_REQ:  nxt = TBL_WAIT;
      TBL_WAIT: nxt = (i_ruleTbl_rdata_valid || timeout) ? RESP : TBL_WAIT;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cls_q <= '0;
      idx_q <= '0;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state <= nxt;
      drop_q <= i_rule_rden && state != IDLE;
      if (state == IDLE && i_rule_rden) begin
        cls_q <= i_rule_addr[10:8];
        idx_q <= i_rule_addr[5:0];
      end
      if (state == TBL_REQ) cnt <= '0;
      else if (state == TBL_WAIT) cnt <= cnt + 1'b1;
      if (state == LOCAL) begin
        rdata_q <= pk_data;
        err_q <= pk_ill;
      end else if (state == TBL_WAIT && i_ruleTbl_rdata_valid) begin
        rdata_q <= i_ruleTbl_rdata;
        err_q <= 1'b0;
      end else if (state == TBL_WAIT && timeout) begin
        rdata_q <= 32'hDEAD_BEEF;
        err_q <= 1'b1;
      end
    end
  end
  assign o_rule_rdata_valid = state == RESP;
  assign o_rule_rd_err = state == RESP && err_q;
  assign o_rule_rdata = rdata_q;
  assign o_rule_busy = state != IDLE;
  assign o_rule_drop = drop_q;
  assign o_ruleTbl_rden = state == TBL_REQ;
  assign o_ruleTbl_addr = idx_q;
endmodule

// File: tb/tb_rule_readback_for_dep.sv
// tb_rule_readback_for_dep: directed readback scenarios with hand-computed expectations
module tb_rule_readback_for_dep;
  import rule_readback_for_dep_pkg::*;
  localparam int RD_TIMEOUT = 64;
  logic clk = 1'b0, rst_n = 1'b0, rden = 1'b0, rdata_valid, rd_err, busy, drop;
  logic [31:0] addr = '0, rdata, tbl_rdata = '0;
  logic tbl_rden, tbl_valid = 1'b0;
  logic [5:0] tbl_addr;
  logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0] type_data = '0, type_mask = '0;
  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] type_offset = '0;
  logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0] key_offset = '0;
  logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH-1:0] key_replace = '0;
  logic [HEAD_SHIFT_WIDTH-1:0] head_shift = '0;
  logic [META_SHIFT_WIDTH-1:0] meta_shift = '0;
  logic [4:0] st;
  int total = 0, bad = 0, resp_cnt = 0, rden_pulses = 0, r0, p0;
  logic early;

  rule_readback_for_dep #(.RD_TIMEOUT(RD_TIMEOUT), .TO_WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rule_rden(rden), .i_rule_addr(addr),
    .o_rule_rdata_valid(rdata_valid), .o_rule_rdata(rdata), .o_rule_rd_err(rd_err),
    .o_rule_busy(busy), .o_rule_drop(drop),
    .i_typeRule_typeData(type_data), .i_typeRule_typeMask(type_mask),
    .i_typeRule_typeOffset(type_offset), .i_typeRule_keyOffset(key_offset),
    .i_typeRule_keyReplaceOffset(key_replace), .i_typeRule_headShift(head_shift),
    .i_typeRule_metaShift(meta_shift),
    .o_ruleTbl_rden(tbl_rden), .o_ruleTbl_addr(tbl_addr),
    .i_ruleTbl_rdata_valid(tbl_valid), .i_ruleTbl_rdata(tbl_rdata)
  );

  always #5 clk = ~clk;
  assign st = {rdata_valid, rd_err, busy, drop, tbl_rden};
  always @(negedge clk) begin
    if (rdata_valid) resp_cnt++;
    if (tbl_rden) rden_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // status order: valid, err, busy, drop, table rden
  task automatic read_local(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
    rden = 1'b1;
    addr = a;
    tick();
    rden = 1'b0;
    chk({tag, " req"}, st, 5'b00100);
    tick();
    chk({tag, " resp"}, st, {1'b1, e, 3'b100});
    chk({tag, " data"}, rdata, d);
    tick();
    chk({tag, " idle"}, st, 5'b00000);
  endtask

  initial begin
    type_data[1] = 16'h1234;
    type_mask[1] = 16'hABCD;
    type_offset[2] = 8'h44;
    key_offset[2] = 9'h103;
    key_replace[2] = 8'h07;
    head_shift = 8'd5;
    meta_shift = 8'h9A;
    tick();
    tick();
    chk("reset status", st, 5'b00000);
    chk("reset rdata", rdata, 32'h0);
    chk("reset tbl_addr", tbl_addr, 6'd0);
    rst_n = 1'b1;
    tick();

    read_local("head", 32'h400, 32'h0000_0005, 1'b0);
    read_local("key2", 32'h302, 32'h0001_0703, 1'b0);
    read_local("type1", 32'h101, 32'h1234_ABCD, 1'b0);
    read_local("toff2", 32'h202, 32'h0000_0044, 1'b0);
    read_local("meta", 32'h500, 32'h0000_009A, 1'b0);
    read_local("type idx4", 32'h104, 32'h0, 1'b1);
    read_local("key idx8", 32'h308, 32'h0, 1'b1);
    p0 = rden_pulses;
    read_local("tbl idx32", 32'h020, 32'h0, 1'b1);
    chk("tbl idx32 no access", rden_pulses - p0, 0);

    rden = 1'b1;
    addr = 32'h400;
    tick();
    rden = 1'b0;
    head_shift = 8'd6;
    tick();
    head_shift = 8'd7;
    chk("cfg local sample", rdata, 32'h6);
    tick();
    chk("cfg hold", rdata, 32'h6);

    r0 = resp_cnt;
    rden = 1'b1;
    addr = 32'h400;
    tick();
    rden = 1'b0;
    tick();
    chk("resp edge status", st, 5'b10100);
    rden = 1'b1;
    addr = 32'h500;
    tick();
    rden = 1'b0;
    chk("resp edge drop", st, 5'b00010);
    tick();
    tick();
    chk("resp edge not served", st, 5'b00000);
    chk("resp edge count", resp_cnt - r0, 1);

    r0 = resp_cnt;
    rden = 1'b1;
    addr = 32'h700;
    tick();
    addr = 32'h400;
    tick();
    rden = 1'b0;
    chk("cls7 resp drop", st, 5'b11110);
    chk("cls7 data", rdata, 32'h0);
    tick();
    chk("cls7 drop once", st, 5'b00000);
    tick();
    tick();
    chk("cls7 one resp", resp_cnt - r0, 1);

    tbl_valid = 1'b1;
    tbl_rdata = 32'h0BAD;
    tick();
    tbl_valid = 1'b0;
    chk("idle tbl valid ignored", st, 5'b00000);
    r0 = resp_cnt;
    p0 = rden_pulses;
    rden = 1'b1;
    addr = 32'h003;
    tick();
    rden = 1'b0;
    chk("tbl req status", st, 5'b00101);
    chk("tbl req addr", tbl_addr, 6'd3);
    tick();
    chk("tbl wait status", st, 5'b00100);
    tick();
    tick();
    tbl_valid = 1'b1;
    tbl_rdata = 32'h1;
    tick();
    tbl_valid = 1'b0;
    chk("tbl resp status", st, 5'b10100);
    chk("tbl resp data", rdata, 32'h1);
    tick();
    chk("tbl idle", st, 5'b00000);
    chk("tbl one rden", rden_pulses - p0, 1);
    chk("tbl one resp", resp_cnt - r0, 1);

    rden = 1'b1;
    addr = 32'h000;
    tick();
    rden = 1'b0;
    early = 1'b0;
    for (int i = 0; i < RD_TIMEOUT + 1; i++) begin
      tick();
      early = early | rdata_valid;
    end
    chk("timeout not early", early, 1'b0);
    tick();
    chk("timeout status", st, 5'b11100);
    chk("timeout data", rdata, 32'hDEAD_BEEF);
    tick();
    r0 = resp_cnt;
    tbl_valid = 1'b1;
    tbl_rdata = 32'h55;
    tick();
    tbl_valid = 1'b0;
    tick();
    chk("late valid ignored", st, 5'b00000);
    chk("late valid data", rdata, 32'hDEAD_BEEF);
    chk("late valid no resp", resp_cnt - r0, 0);

    rden = 1'b1;
    addr = 32'h001;
    tick();
    rden = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid reset status", st, 5'b00000);
    chk("mid reset data", rdata, 32'h0);
    chk("mid reset tbl_addr", tbl_addr, 6'd0);
    #2;
    rst_n = 1'b1;
    r0 = resp_cnt;
    tbl_valid = 1'b1;
    tbl_rdata = 32'h77;
    tick();
    tbl_valid = 1'b0;
    tick();
    chk("post reset ignored", st, 5'b00000);
    chk("post reset no resp", resp_cnt - r0, 0);
    read_local("after reset", 32'h400, 32'h7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
